// File: rtl/ahb_pkg.sv
// Shared AHB encodings and arbiter state type.
// Used by the arbiter, its winner selector and the bus interface.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;
  localparam logic [1:0] HRESP_RETRY = 2'b10;
  localparam logic [1:0] HRESP_SPLIT = 2'b11;

  typedef enum logic {
    PARK  = 1'b0,
    OWNED = 1'b1
  } arb_state_e;

endpackage

// File: rtl/ahb_arbiter_if.sv
// Arbitration signals between the AHB masters/muxes and the arbiter.
// Handshake: a master holds hbusreq high until it sees its hgrant bit; grant only moves on boundaries or RETRY/SPLIT.
interface ahb_arbiter_if #(
  parameter int NUM_MASTERS = 2
);
  logic [NUM_MASTERS-1:0] hbusreq;
  logic [1:0]             htrans;
  logic                   hready;
  logic [1:0]             hresp;
  logic [NUM_MASTERS-1:0] hgrant;
  logic [1:0]             hmaster;
  logic [1:0]             hmaster_d;

  modport master (
    output hbusreq, htrans, hready, hresp,
    input  hgrant, hmaster, hmaster_d
  );

  modport slave (
    input  hbusreq, htrans, hready, hresp,
    output hgrant, hmaster, hmaster_d
  );
endinterface

// File: rtl/ahb_arb_pick.sv
// Combinational winner selector: round-robin from start_i+1 or fixed lowest-index priority.
// With excl_i set the owner is skipped unless it is the only requester.
module ahb_arb_pick #(
  parameter int NUM_MASTERS = 2,
  parameter bit RR_EN       = 1'b0
) (
  input  logic [3:0] req_i,
  input  logic [1:0] owner_i,
  input  logic [1:0] start_i,
  input  logic       excl_i,
  output logic [1:0] winner_o,
  output logic       any_o
);

  logic [3:0] others;
  logic [3:0] cand;
  logic [1:0] idx;
  int         idx_int;
  logic       found;

  always_comb begin
    others   = req_i & ~(4'b0001 << owner_i);
    cand     = (excl_i && (others != 4'b0000)) ? others : req_i;
    any_o    = |req_i;
    winner_o = owner_i;
    found    = 1'b0;
    idx_int  = 0;
    idx      = 2'd0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      idx_int = RR_EN ? ((int'(start_i) + 1 + i) % NUM_MASTERS) : i;
      idx     = idx_int[1:0];
      if (!found && cand[idx]) begin
        winner_o = idx;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ahb_arbiter.sv
// AHB bus arbiter with hold-limit and RETRY/SPLIT-forced re-arbitration.
// Define AHB_ARB_RR_EN for round-robin selection; otherwise fixed lowest-index priority.
module ahb_arbiter
  import ahb_pkg::*;
#(
  parameter int NUM_MASTERS    = 2,
  parameter int MAX_HOLD       = 16,
  parameter int DEFAULT_MASTER = 0
) (
  input  logic          hclk,
  input  logic          hreset,
  ahb_arbiter_if.slave  bus,
  output arb_state_e    state_o,
  output logic [7:0]    hold_cnt_o
);

  localparam logic [1:0] DEF_IDX  = 2'(DEFAULT_MASTER);
  localparam logic [7:0] HOLD_MAX = 8'(MAX_HOLD);
  localparam logic [NUM_MASTERS-1:0] DEF_GRANT = (NUM_MASTERS)'(1 << DEFAULT_MASTER);

  arb_state_e             state_q, state_d;
  logic [1:0]             owner_q, owner_d;
  logic [1:0]             mdata_q, mdata_d;
  logic [7:0]             hold_q, hold_d;
  logic [NUM_MASTERS-1:0] grant_q, grant_d;

  logic [3:0] req;
  logic [3:0] others;
  logic       owner_req, boundary, force_rsp, hold_hit, excl, rearb, any;
  logic [1:0] winner, start;

  assign req       = 4'(bus.hbusreq);
  assign owner_req = req[owner_q];
  assign others    = req & ~(4'b0001 << owner_q);
  assign boundary  = bus.hready && (bus.htrans == HTRANS_IDLE || bus.htrans == HTRANS_NONSEQ);
  assign force_rsp = bus.hready && (bus.hresp == HRESP_RETRY || bus.hresp == HRESP_SPLIT);
  assign hold_hit  = (state_q == OWNED) && (hold_q >= HOLD_MAX) && (others != 4'b0000);
  assign excl      = force_rsp || hold_hit;
  // RETRY/SPLIT ignores htrans; everything else waits for a burst boundary.
  assign rearb     = force_rsp ||
                     (boundary && (state_q == PARK || !owner_req || hold_hit));

`ifdef AHB_ARB_RR_EN
  localparam bit RR_EN = 1'b1;
  logic [1:0] ptr_q, ptr_d;

  assign start = ptr_q;

  always_comb begin
    ptr_d = ptr_q;
    if (rearb && any) ptr_d = winner;
  end

  always_ff @(posedge hclk) begin
    if (hreset) ptr_q <= DEF_IDX;
    else        ptr_q <= ptr_d;
  end
`else
  localparam bit RR_EN = 1'b0;
  assign start = owner_q;
`endif

  ahb_arb_pick #(
    .NUM_MASTERS (NUM_MASTERS),
    .RR_EN       (RR_EN)
  ) u_pick (
    .req_i    (req),
    .owner_i  (owner_q),
    .start_i  (start),
    .excl_i   (excl),
    .winner_o (winner),
    .any_o    (any)
  );

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    hold_d  = hold_q;
    grant_d = '0;
    mdata_d = bus.hready ? owner_q : mdata_q;
    if (rearb) begin
      if (any) begin
        state_d = OWNED;
        owner_d = winner;
      end else begin
        state_d = PARK;
        owner_d = DEF_IDX;
      end
    end
    // An excluded round that falls back to the owner still restarts its hold window.
    if (state_q == PARK || state_d == PARK || owner_d != owner_q || (rearb && excl)) begin
      hold_d = 8'd0;
    end else if (bus.hready && hold_q < HOLD_MAX) begin
      hold_d = hold_q + 8'd1;
    end
    for (int i = 0; i < NUM_MASTERS; i++) begin
      grant_d[i] = (owner_d == 2'(i));
    end
  end

  always_ff @(posedge hclk) begin
    if (hreset) begin
      state_q <= PARK;
      owner_q <= DEF_IDX;
      mdata_q <= DEF_IDX;
      hold_q  <= 8'd0;
      grant_q <= DEF_GRANT;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      mdata_q <= mdata_d;
      hold_q  <= hold_d;
      grant_q <= grant_d;
    end
  end

  assign bus.hgrant    = grant_q;
  assign bus.hmaster   = owner_q;
  assign bus.hmaster_d = mdata_q;
  assign state_o       = state_q;
  assign hold_cnt_o    = hold_q;

endmodule

// File: tb/tb_ahb_arbiter.sv
// Directed scoreboard bench for ahb_arbiter (two masters, MAX_HOLD=4, parked on M0).
// Expected {state, hgrant, hmaster, hmaster_d} after each edge is queued by the driver and checked by a monitor.
module tb_ahb_arbiter;
  import ahb_pkg::*;

  localparam int W = 7;

  logic       hclk;
  logic       hreset;
  arb_state_e state_o;
  logic [7:0] hold_cnt;

  ahb_arbiter_if #(.NUM_MASTERS(2)) bus ();

  ahb_arbiter #(
    .NUM_MASTERS    (2),
    .MAX_HOLD       (4),
    .DEFAULT_MASTER (0)
  ) dut (
    .hclk       (hclk),
    .hreset     (hreset),
    .bus        (bus),
    .state_o    (state_o),
    .hold_cnt_o (hold_cnt)
  );

  logic [W-1:0] exp_q[$];
  string        name_q[$];
  int           n_checks = 0;
  int           n_fail   = 0;

  // clock / reset
  initial begin
    hclk = 1'b0;
    forever #5 hclk = ~hclk;
  end

  // scoreboard monitor
  always @(negedge hclk) begin
    logic [W-1:0] exp_v;
    logic [W-1:0] act_v;
    string        nm;
    if (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      nm    = name_q.pop_front();
      act_v = {state_o == OWNED, bus.hgrant, bus.hmaster, bus.hmaster_d};
      n_checks++;
      if (act_v !== exp_v) begin
        n_fail++;
        $display("FAIL %s: state/hgrant/hmaster/hmaster_d got %b want %b (hold_cnt=%0d)",
                 nm, act_v, exp_v, hold_cnt);
      end
    end
  end

  // driver: apply one cycle of inputs and queue the outputs expected after that edge
  task automatic step(input logic rst, input logic [1:0] req, input logic [1:0] tr,
                      input logic rdy, input logic [1:0] rsp, input logic st,
                      input logic [1:0] m, input logic [1:0] md, input string nm);
    logic [1:0] g;
    hreset      = rst;
    bus.hbusreq = req;
    bus.htrans  = tr;
    bus.hready  = rdy;
    bus.hresp   = rsp;
    g = (m == 2'd0) ? 2'b01 : 2'b10;
    @(posedge hclk);
    #1;
    exp_q.push_back({st, g, m, md});
    name_q.push_back(nm);
  endtask

  initial begin
    logic       cur;
    logic       prev;
    logic [1:0] rr_m;

    hreset      = 1'b1;
    bus.hbusreq = 2'b00;
    bus.htrans  = HTRANS_IDLE;
    bus.hready  = 1'b1;
    bus.hresp   = HRESP_OKAY;

    step(1, 2'b00, HTRANS_IDLE, 1, HRESP_OKAY, 0, 0, 0, "reset");
    step(1, 2'b00, HTRANS_IDLE, 1, HRESP_OKAY, 0, 0, 0, "reset");
    repeat (5) step(0, 2'b00, HTRANS_IDLE, 1, HRESP_OKAY, 0, 0, 0, "idle_park");

    step(0, 2'b10, HTRANS_IDLE,   1, HRESP_OKAY, 1, 1, 0, "park_to_m1");
    step(0, 2'b10, HTRANS_NONSEQ, 1, HRESP_OKAY, 1, 1, 1, "hmaster_d_follow");

    // M1 burst with M0 requesting from beat 2 and two wait states
    step(0, 2'b10, HTRANS_NONSEQ, 1, HRESP_OKAY, 1, 1, 1, "burst_b1");
    step(0, 2'b11, HTRANS_SEQ,    1, HRESP_OKAY, 1, 1, 1, "burst_b2");
    step(0, 2'b11, HTRANS_SEQ,    0, HRESP_OKAY, 1, 1, 1, "burst_wait");
    step(0, 2'b11, HTRANS_SEQ,    0, HRESP_OKAY, 1, 1, 1, "burst_wait");
    step(0, 2'b11, HTRANS_SEQ,    1, HRESP_OKAY, 1, 1, 1, "burst_b3");
    step(0, 2'b11, HTRANS_SEQ,    1, HRESP_OKAY, 1, 1, 1, "burst_b4");
    step(0, 2'b11, HTRANS_IDLE,   1, HRESP_OKAY, 1, 0, 1, "burst_end_handover");

    // both request: hold count 0..3 keeps the owner, reaching 4 hands over
    cur = 1'b0;
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 5; i++) begin
        prev = cur;
        if (i == 4) cur = ~cur;
        step(0, 2'b11, HTRANS_NONSEQ, 1, HRESP_OKAY, 1, {1'b0, cur}, {1'b0, prev}, "hold_rotate");
      end
    end

    step(0, 2'b11, HTRANS_NONSEQ, 1, HRESP_ERROR, 1, 0, 0, "error_keeps");
    step(0, 2'b11, HTRANS_NONSEQ, 1, HRESP_RETRY, 1, 1, 0, "retry_moves");
    step(0, 2'b11, HTRANS_NONSEQ, 1, HRESP_OKAY,  1, 1, 1, "after_retry");
    step(0, 2'b11, HTRANS_SEQ,    1, HRESP_SPLIT, 1, 0, 1, "split_mid_burst");
    step(0, 2'b10, HTRANS_NONSEQ, 1, HRESP_OKAY,  1, 1, 0, "drop_handover");
    step(0, 2'b00, HTRANS_IDLE,   1, HRESP_OKAY,  0, 0, 1, "drop_park");

    step(0, 2'b10, HTRANS_IDLE,   1, HRESP_OKAY, 1, 1, 0, "m1_grant");
    step(0, 2'b10, HTRANS_NONSEQ, 0, HRESP_OKAY, 1, 1, 0, "hmaster_d_wait");
    step(0, 2'b10, HTRANS_NONSEQ, 1, HRESP_OKAY, 1, 1, 1, "m1_nonseq");
    step(1, 2'b10, HTRANS_SEQ,    1, HRESP_OKAY, 0, 0, 0, "reset_mid_burst");
    step(0, 2'b00, HTRANS_IDLE,   1, HRESP_OKAY, 0, 0, 0, "post_reset_park");

`ifdef AHB_ARB_RR_EN
    rr_m = 2'd1;
`else
    rr_m = 2'd0;
`endif
    step(0, 2'b11, HTRANS_IDLE, 1, HRESP_OKAY, 1, rr_m, 0,    "both_from_park");
    step(0, 2'b00, HTRANS_IDLE, 1, HRESP_OKAY, 0, 0,    rr_m, "final_park");

    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge hclk);
    @(posedge hclk);
    if (exp_q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d expected entries left, want 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ahb_arbiter.md
# ahb_arbiter

Bus arbiter for the AHB interconnect. It takes `hbusreq` from up to four master tops and drives each master's `hgrant` input. It also drives `hmaster` and `hmaster_d`, which the address/control mux and the write-data/decoder muxes use to select the current owner. Arbitration is round-robin or fixed-priority, and a hold-limit counter stops any master from monopolising the bus.

## Interface
Parameters:
- `NUM_MASTERS`, 2: number of requesting masters, legal range 2..4.
- `MAX_HOLD`, 16: address-phase transfers (hready-high cycles) a master may own the bus before forced re-arbitration. Legal range 2..255.
- `DEFAULT_MASTER`, 0: master parked on the bus when nobody requests.

Ports:
- `hclk`  in  1: bus clock, all state on rising edge.
- `hreset`  in  1: synchronous, active-high reset.
- `hbusreq`  in  NUM_MASTERS: per-master bus request.
- `htrans`  in  2: muxed htrans of the current address-phase owner (00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ).
- `hready`  in  1: muxed slave ready.
- `hresp`  in  2: muxed slave response (00 OKAY, 01 ERROR, 10 RETRY, 11 SPLIT).
- `hgrant`  out  NUM_MASTERS: one-hot grant, registered.
- `hmaster`  out  2: index of the address-phase owner, registered.
- `hmaster_d`  out  2: index of the data-phase owner, registered.

## Operation
- FSM states:
  - PARK: default master granted, no request outstanding.
  - OWNED: a requesting master is granted.
- Boundary cycle: `hready`=1 and `htrans` is IDLE or NONSEQ. Grant never moves while `htrans` is SEQ or BUSY, so bursts are never broken.
- Re-arbitration takes place on a boundary cycle when any of these holds:
  - the owner's `hbusreq`=0;
  - `hold_cnt`>=MAX_HOLD and another master requests;
  - the state is PARK.
- Response-forced re-arbitration: `hresp`=RETRY or SPLIT with `hready`=1 forces re-arbitration on that cycle, regardless of `htrans`. The owner is excluded from that round.
  - ERROR does not force re-arbitration.
- Winner selection:
  - With round-robin, the search starts at owner+1 modulo NUM_MASTERS.
  - A hold-limit round excludes the owner. If only the owner requests, it keeps the bus and `hold_cnt` clears.
  - If no master requests, the bus parks on DEFAULT_MASTER (state PARK).
- `hold_cnt`, 8-bit:
  - increments on every `hready`=1 cycle in OWNED;
  - saturates at MAX_HOLD;
  - clears on any grant change and in PARK.
- Bits of `hbusreq` at index >= NUM_MASTERS are ignored.
- Reset mid-burst: grant returns to DEFAULT_MASTER immediately. In-flight transfers are abandoned, and the masters' own resets handle recovery.

## Timing
- The decision is made combinationally in cycle N. `hgrant` and `hmaster` update at the edge ending cycle N, so they are visible in N+1. Latency from request to grant is 1 cycle when the bus is parked.
- `hmaster_d` <= `hmaster` on every edge where `hready`=1. It holds while `hready`=0, which covers wait states.
- `hgrant` is always exactly one-hot and is never all-zero.
- Simultaneous events:
  - Owner drop plus new request in the same cycle: the new requester wins in one cycle, with no PARK bubble.
  - Hold-limit and RETRY in the same cycle: handled as RETRY, with the same exclusion rule.
- Reset values:
  - `hgrant`=one-hot(DEFAULT_MASTER)
  - `hmaster`=DEFAULT_MASTER
  - `hmaster_d`=DEFAULT_MASTER
  - state=PARK
  - `hold_cnt`=0
  - round-robin pointer=DEFAULT_MASTER

## Configuration
- `AHB_ARB_RR_EN` defined: round-robin search as described above.
- `AHB_ARB_RR_EN` undefined: fixed priority, lowest index wins. The exclusion rule for hold-limit and RETRY/SPLIT still applies, so a low index cannot starve others indefinitely. The round-robin pointer logic is not built.

## Structure
- Shared package `ahb_pkg` holds:
  - htrans constants IDLE/BUSY/NONSEQ/SEQ;
  - hresp constants OKAY/ERROR/RETRY/SPLIT;
  - the arbiter state enum PARK/OWNED.
- One natural sub-module, `ahb_arb_pick`: a combinational winner selector. Inputs are requests, the owner index, the exclude flag and mode; outputs are the winner index and an any-request flag.

## Test plan
- Reset, then idle for 5 cycles: `hgrant`=01, `hmaster`=0, `hmaster_d`=0 throughout.
- M1 raises `hbusreq` with the bus parked on M0: `hgrant`=10 and `hmaster`=1 one cycle later. `hmaster_d`=1 after the next `hready`=1 edge.
- M1 runs a 4-beat SEQ burst while M0 requests from beat 2, with `hready` low for 2 cycles mid-burst. The grant stays with M1 until the NONSEQ/IDLE after the last beat, then moves to M0.
- Both masters hold requests continuously with NONSEQ transfers, MAX_HOLD=4. With RR, the grant alternates every 4 transfers. With the macro off, M0 wins and M1 gets the bus after each 4-transfer hold limit.
- Slave returns RETRY (`hresp`=10, `hready`=1) to M0 while M1 requests: the grant moves to M1 on the next cycle even though M0 keeps its request.
- `hreset` asserted mid-burst of M1: the next cycle shows `hgrant`=01, `hmaster`=0 and `hmaster_d`=0.
